// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: client request and i2c_master command signals for the
// shared-i2c arbiter.
//   client side : req, req_rd, req_chip_addr, req_reg_addr, req_wdata (to arbiter)
//                 grant, ack, rdata, err (from arbiter)
//   master side : m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
//                 (from arbiter); m_busy, m_status, m_data_out (to arbiter)
// Modport master = arbiter view, modport slave = clients plus i2c_master view.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rd;
  logic [7*NUM_REQ-1:0] req_chip_addr;
  logic [8*NUM_REQ-1:0] req_reg_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           rdata;
  logic                 err;
  logic [6:0]           m_chip_addr;
  logic [7:0]           m_reg_addr;
  logic [7:0]           m_data_in;
  logic                 m_write_en;
  logic                 m_read_en;
  logic                 m_busy;
  logic [2:0]           m_status;
  logic [7:0]           m_data_out;

  modport master (
    input  req, req_rd, req_chip_addr, req_reg_addr, req_wdata,
    input  m_busy, m_status, m_data_out,
    output grant, ack, rdata, err,
    output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );

  modport slave (
    output req, req_rd, req_chip_addr, req_reg_addr, req_wdata,
    output m_busy, m_status, m_data_out,
    input  grant, ack, rdata, err,
    input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_master between NUM_REQ
// single-register read/write clients, with start and transfer watchdogs.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    i2c_bus_arbiter_if.master (client request/grant/ack/rdata/err and
//          i2c_master command/busy/status/data signals)
//
// state   | meaning
// S_IDLE  | scan requests from rr, latch the winner's fields, raise grant
// S_ISSUE | one-cycle read or write command pulse to the i2c_master
// S_START | wait for m_busy to rise, bounded by START_TIMEOUT
// S_XFER  | wait for m_busy to fall, bounded by XFER_TIMEOUT
// S_RESP  | one-cycle ack/err to the granted client, advance rr
module i2c_bus_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int START_TIMEOUT = 64,
  parameter int XFER_TIMEOUT  = 200000,
  parameter int TW            = 18
) (
  input  logic clk,
  input  logic reset,
  i2c_bus_arbiter_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_START,
    S_XFER,
    S_RESP
  } state_t;

  state_t         state;
  logic [IW-1:0]  rr;
  logic [IW-1:0]  cur;
  logic [IW-1:0]  pick;
  logic           found;
  logic           rd;
  logic [TW-1:0]  wd;

  // First asserted request at or after rr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      rr              <= '0;
      cur             <= '0;
      rd              <= 1'b0;
      wd              <= '0;
      bus.grant       <= '0;
      bus.ack         <= '0;
      bus.err         <= 1'b0;
      bus.rdata       <= '0;
      bus.m_chip_addr <= '0;
      bus.m_reg_addr  <= '0;
      bus.m_data_in   <= '0;
      bus.m_write_en  <= 1'b0;
      bus.m_read_en   <= 1'b0;
    end else begin
      // ack, err and the command strobes are single-cycle pulses.
      bus.m_write_en <= 1'b0;
      bus.m_read_en  <= 1'b0;
      bus.ack        <= '0;
      bus.err        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (found) begin
            cur             <= pick;
            rd              <= bus.req_rd[pick];
            bus.grant       <= ONE_HOT0 << pick;
            bus.m_chip_addr <= bus.req_chip_addr[7*pick +: 7];
            bus.m_reg_addr  <= bus.req_reg_addr[8*pick +: 8];
            bus.m_data_in   <= bus.req_wdata[8*pick +: 8];
            // Registered strobe: high during the S_ISSUE cycle.
            bus.m_read_en   <= bus.req_rd[pick];
            bus.m_write_en  <= ~bus.req_rd[pick];
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd    <= '0;
          state <= S_START;
        end

        S_START: begin
          if (bus.m_busy) begin
            wd    <= '0;
            state <= S_XFER;
          end else if (wd == START_LAST) begin
            bus.err <= 1'b1;
            bus.ack <= bus.grant;
            state   <= S_RESP;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end

        S_XFER: begin
          if (!bus.m_busy) begin
            if (rd) bus.rdata <= bus.m_data_out;
            bus.err <= (bus.m_status != 3'd0);
            bus.ack <= bus.grant;
            state   <= S_RESP;
          end else if (wd == XFER_LAST) begin
            bus.err <= 1'b1;
            bus.ack <= bus.grant;
            state   <= S_RESP;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end

        S_RESP: begin
          bus.grant <= '0;
          rr        <= (int'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
  localparam int N = 3;

  typedef struct {
    int         client;
    logic       rd;
    logic [6:0] chip;
    logic [7:0] regad;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         kind;   // 0 normal, 1 start timeout, 2 transfer timeout
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_REQ(N)) ifc ();

  i2c_bus_arbiter #(
    .NUM_REQ(N), .START_TIMEOUT(64), .XFER_TIMEOUT(1000), .TW(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  logic [7:0] last_rdata = 8'h00;

  // Request levels: a client's req is high while it has unacked posts.
  int posted[N];
  int acked[N];
  int cancelled[N];
  logic [N-1:0] req_v;
  always_comb begin
    for (int c = 0; c < N; c++) req_v[c] = (posted[c] != acked[c] + cancelled[c]);
  end
  assign ifc.req = req_v;

  // i2c_master model controls.
  int         mdl_mode   = 0;   // 0 normal, 1 never busy, 2 busy until released
  int         mdl_len    = 10;
  logic [2:0] mdl_status = 3'd0;
  logic [7:0] mdl_data   = 8'h00;
  logic       release_busy = 1'b0;
  int         busy_cyc = 0;
  int         fall_cyc = 0;
  int         pulse_cyc = 0;
  int         pulses_this = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // i2c_master model.
  initial begin
    ifc.m_busy = 1'b0;
    ifc.m_status = 3'd0;
    ifc.m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && (ifc.m_write_en || ifc.m_read_en) && mdl_mode != 1) begin
        @(negedge clk);
        ifc.m_busy = 1'b1;
        busy_cyc = cyc;
        if (mdl_mode == 0) begin
          repeat (mdl_len) @(negedge clk);
        end else begin
          wait (release_busy);
          @(negedge clk);
        end
        ifc.m_status = (mdl_mode == 0) ? mdl_status : 3'd0;
        ifc.m_data_out = mdl_data;
        ifc.m_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Command and completion monitor against the scoreboard.
  initial begin
    exp_t e;
    int d;
    for (int c = 0; c < N; c++) acked[c] = 0;
    forever begin
      @(negedge clk);
      if (reset) pulses_this = 0;
      if (ifc.m_write_en || ifc.m_read_en) begin
        pulse_cyc = cyc;
        pulses_this++;
        chk("cmd_exclusive", {31'd0, ifc.m_write_en & ifc.m_read_en}, 32'd0);
        if (sb.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
        else begin
          e = sb[0];
          chk("cmd_read_en", {31'd0, ifc.m_read_en}, {31'd0, e.rd});
          chk("cmd_chip", {25'd0, ifc.m_chip_addr}, {25'd0, e.chip});
          chk("cmd_reg", {24'd0, ifc.m_reg_addr}, {24'd0, e.regad});
          chk("cmd_wdata", {24'd0, ifc.m_data_in}, {24'd0, e.wdata});
          chk("cmd_grant", {29'd0, ifc.grant}, 32'd1 << e.client);
        end
      end
      if (ifc.ack != '0) begin
        if (sb.size() == 0) chk("ack_unexpected", {29'd0, ifc.ack}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("ack_onehot", {29'd0, ifc.ack}, 32'd1 << e.client);
          chk("ack_grant", {29'd0, ifc.grant}, 32'd1 << e.client);
          chk("ack_err", {31'd0, ifc.err}, {31'd0, e.err});
          chk("ack_rdata", {24'd0, ifc.rdata}, {24'd0, e.rdata});
          chk("one_pulse_per_grant", pulses_this, 1);
          if (e.kind == 0) begin
            chk("ack_after_busy_fall", cyc - fall_cyc, 1);
          end else if (e.kind == 1) begin
            d = cyc - pulse_cyc;
            chk("start_timeout_window", {31'd0, (d >= 64 && d <= 67)}, 32'd1);
          end else begin
            d = cyc - busy_cyc;
            chk("xfer_timeout_window", {31'd0, (d >= 1000 && d <= 1003)}, 32'd1);
          end
          acked[e.client]++;
        end
        pulses_this = 0;
      end
    end
  end

  task automatic post(input int c, input logic rd, input logic [6:0] chip,
                      input logic [7:0] regad, input logic [7:0] wdata, input int kind);
    exp_t e;
    e.client = c; e.rd = rd; e.chip = chip; e.regad = regad; e.wdata = wdata;
    e.kind = kind;
    e.err = (kind != 0) ? 1'b1 : (mdl_status != 3'd0);
    e.rdata = (rd && kind == 0) ? mdl_data : last_rdata;
    last_rdata = e.rdata;
    sb.push_back(e);
    ifc.req_rd[c] = rd;
    ifc.req_chip_addr[7*c +: 7] = chip;
    ifc.req_reg_addr[8*c +: 8] = regad;
    ifc.req_wdata[8*c +: 8] = wdata;
    posted[c]++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int c = 0; c < N; c++) begin posted[c] = 0; cancelled[c] = 0; end
    ifc.req_rd = '0;
    ifc.req_chip_addr = '0;
    ifc.req_reg_addr = '0;
    ifc.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {29'd0, ifc.grant}, 32'd0);
    chk("rst_ack", {29'd0, ifc.ack}, 32'd0);
    chk("rst_cmd", {30'd0, ifc.m_write_en, ifc.m_read_en}, 32'd0);
    chk("rst_fields", {9'd0, ifc.m_chip_addr, ifc.m_reg_addr, ifc.m_data_in}, 32'd0);
    chk("rst_rdata_err", {23'd0, ifc.rdata, ifc.err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_grant", {29'd0, ifc.grant}, 32'd0);

    // Single write from client 1, busy 50 cycles.
    mdl_mode = 0; mdl_len = 50; mdl_status = 3'd0; mdl_data = 8'h11;
    post(1, 1'b0, 7'h72, 8'h41, 8'h00, 0);
    wait_done("done_write", 200);

    // Read from client 0 returning 0xA5.
    mdl_len = 20; mdl_data = 8'hA5;
    post(0, 1'b1, 7'h39, 8'h42, 8'h00, 0);
    wait_done("done_read", 200);

    // Client 2 write brings rr back to 0.
    mdl_len = 5;
    post(2, 1'b0, 7'h10, 8'h20, 8'h33, 0);
    wait_done("done_rr_align", 100);

    // Contention: all three pending, client 0 twice; order 0,1,2,0.
    mdl_len = 8;
    post(0, 1'b0, 7'h01, 8'h10, 8'hA0, 0);
    post(1, 1'b0, 7'h02, 8'h11, 8'hA1, 0);
    post(2, 1'b0, 7'h03, 8'h12, 8'hA2, 0);
    post(0, 1'b0, 7'h01, 8'h10, 8'hA0, 0);
    wait_done("done_contention", 400);

    // No-start timeout on client 1, then client 2 serviced normally.
    mdl_mode = 1;
    post(1, 1'b0, 7'h50, 8'h01, 8'h02, 1);
    wait_done("done_start_timeout", 200);
    mdl_mode = 0; mdl_len = 12; mdl_data = 8'h6E;
    post(2, 1'b1, 7'h51, 8'h03, 8'h00, 0);
    wait_done("done_after_start_timeout", 200);

    // Stuck busy on a read from client 0: transfer timeout, rdata held.
    mdl_mode = 2; mdl_data = 8'hFF;
    post(0, 1'b1, 7'h52, 8'h04, 8'h00, 2);
    wait_done("done_xfer_timeout", 1500);
    release_busy = 1'b1;
    n = 0;
    while (ifc.m_busy && n < 20) begin @(negedge clk); n++; end
    chk("busy_released", {31'd0, ifc.m_busy}, 32'd0);
    release_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Nonzero status on a write from client 1: err set, rdata unchanged.
    mdl_mode = 0; mdl_len = 15; mdl_status = 3'b010; mdl_data = 8'h77;
    post(1, 1'b0, 7'h53, 8'h05, 8'h9C, 0);
    wait_done("done_status_err", 200);
    mdl_status = 3'd0;

    // Reset in the middle of a client 2 transfer (rr is 2 beforehand).
    mdl_mode = 2;
    post(2, 1'b1, 7'h54, 8'h06, 8'h00, 0);
    n = 0;
    while (!ifc.m_busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_before_reset", {31'd0, ifc.m_busy}, 32'd1);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_grant", {29'd0, ifc.grant}, 32'd0);
    chk("midrst_ack", {29'd0, ifc.ack}, 32'd0);
    chk("midrst_cmd", {30'd0, ifc.m_write_en, ifc.m_read_en}, 32'd0);
    chk("midrst_fields", {9'd0, ifc.m_chip_addr, ifc.m_reg_addr, ifc.m_data_in}, 32'd0);
    chk("midrst_rdata_err", {23'd0, ifc.rdata, ifc.err}, 32'd0);
    sb.delete();
    cancelled[2]++;
    last_rdata = 8'h00;
    release_busy = 1'b1;
    repeat (3) @(negedge clk);
    release_busy = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // rr restarted at 0: client 0 wins over client 2.
    mdl_mode = 0; mdl_len = 10; mdl_data = 8'h3C;
    post(0, 1'b0, 7'h60, 8'h07, 8'h44, 0);
    post(2, 1'b1, 7'h61, 8'h08, 8'h00, 0);
    wait_done("done_after_reset", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
